// File: rtl/pipe_trace_mon_if.sv
// Trace record port: the monitor offers one timestamped record per cycle,
// and the consumer takes it by raising tr_ready.
interface pipe_trace_mon_if #(
    parameter int unsigned PC_W = 32,
    parameter int unsigned TS_W = 16
) ();
    logic            tr_valid;
    logic            tr_ready;
    logic [4:0]      tr_class;
    logic [PC_W-1:0] tr_pc;
    logic [TS_W-1:0] tr_ts;

    modport master (output tr_valid, tr_class, tr_pc, tr_ts, input tr_ready);
    modport slave  (input tr_valid, tr_class, tr_pc, tr_ts, output tr_ready);
endinterface

// File: rtl/pipe_trace_mon.sv
// Instruction-trace monitor: decodes sampled MIPS instructions into classes,
// keeps saturating per-class counts and queues timestamped trace records.
module pipe_trace_mon #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TS_W      = 16,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned DEPTH     = 8,
    parameter bit          TRACE_NOP = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [31:0]              instr,
    input  logic [PC_W-1:0]          pc,
    input  logic                     clr,
    input  logic [4:0]               cnt_sel,
    output logic [CNT_W-1:0]         cnt_val,
    output logic [TS_W-1:0]          cyc,
    pipe_trace_mon_if.master         tr,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned NCLS = 17;

    typedef struct packed {
        logic [4:0]      cls;
        logic [PC_W-1:0] pc;
        logic [TS_W-1:0] ts;
    } rec_t;

    logic [4:0]       cls;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic [CNT_W-1:0] cnt_q [NCLS];
    rec_t             mem   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             push, pop, full, accept, drop;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Instruction class decode
    always_comb begin
        cls = 5'd16;
        if (instr == 32'd0) begin
            cls = 5'd0;
        end else begin
            case (op)
                6'd0: begin
                    case (funct)
                        6'd32:   cls = 5'd1;
                        6'd34:   cls = 5'd2;
                        6'd36:   cls = 5'd3;
                        6'd37:   cls = 5'd4;
                        6'd42:   cls = 5'd5;
                        6'd0:    cls = 5'd6;
                        6'd25:   cls = 5'd7;
                        6'd16:   cls = 5'd8;
                        6'd18:   cls = 5'd9;
                        default: cls = 5'd16;
                    endcase
                end
                6'd9:    cls = 5'd10;
                6'd35:   cls = 5'd11;
                6'd43:   cls = 5'd12;
                6'd4:    cls = 5'd13;
                6'd5:    cls = 5'd14;
                6'd2:    cls = 5'd15;
                default: cls = 5'd16;
            endcase
        end
    end

    assign push   = en && ((cls != 5'd0) || TRACE_NOP);
    assign full   = (level == LW'(DEPTH));
    assign pop    = (level != LW'(0)) && tr.tr_ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Per-class saturating counters; clear wins over a same-cycle sample
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
        end else if (en && (cnt_q[cls] != '1)) begin
            cnt_q[cls] <= cnt_q[cls] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + TS_W'(1);
    end

    // Trace FIFO; a full FIFO still accepts when the head leaves the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= '{cls: cls, pc: pc, ts: cyc};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign cnt_val     = (cnt_sel <= 5'd16) ? cnt_q[cnt_sel] : '0;
    assign fifo_level  = level;
    assign tr.tr_valid = (level != LW'(0));
    assign tr.tr_class = mem[rd_ptr].cls;
    assign tr.tr_pc    = mem[rd_ptr].pc;
    assign tr.tr_ts    = mem[rd_ptr].ts;
endmodule

// File: tb/tb_pipe_trace_mon.sv
// Directed bench for pipe_trace_mon: class counts, FIFO ordering/overflow,
// saturation, clear and mid-run reset.
module tb_pipe_trace_mon;
    localparam logic [31:0] I_ADD   = 32'h0109_5020;
    localparam logic [31:0] I_LW    = 32'h8D09_0004;
    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_SW    = 32'hAD09_0008;
    localparam logic [31:0] I_BEQ   = 32'h1109_0004;
    localparam logic [31:0] I_OTHER = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [31:0] instr, pc;
    logic [4:0]  cnt_sel;
    logic [15:0] cnt_val, cyc, drop_cnt;
    logic [3:0]  fifo_level;
    logic [3:0]  cnt_val4, drop4;
    logic [15:0] cyc4;
    logic [3:0]  level4;

    int n_chk = 0;
    int n_bad = 0;
    int cyc_m = 0;
    int t_first, sw_ts;

    pipe_trace_mon_if #(.PC_W(32), .TS_W(16)) tif ();
    pipe_trace_mon_if #(.PC_W(32), .TS_W(16)) tif4 ();

    pipe_trace_mon dut (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .pc(pc), .clr(clr),
        .cnt_sel(cnt_sel), .cnt_val(cnt_val), .cyc(cyc), .tr(tif),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    pipe_trace_mon #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .pc(pc), .clr(clr),
        .cnt_sel(cnt_sel), .cnt_val(cnt_val4), .cyc(cyc4), .tr(tif4),
        .drop_cnt(drop4), .fifo_level(level4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the cycle-count model follows the reset seen at the edge
    task automatic step();
        @(posedge clk);
        cyc_m = rst ? 0 : cyc_m + 1;
        #1;
    endtask

    task automatic sel(input logic [4:0] s);
        cnt_sel = s;
        #1;
    endtask

    initial begin
        logic [31:0] p1 [4];
        logic [4:0]  c1 [3];
        p1 = '{32'h0, I_ADD, I_LW, I_J};
        c1 = '{5'd1, 5'd11, 5'd15};
        rst = 1'b1; en = 1'b0; clr = 1'b0; instr = '0; pc = '0; cnt_sel = '0;
        tif.tr_ready = 1'b0; tif4.tr_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_cyc", 64'(cyc), 64'(cyc_m));
        chk("rst_valid", 64'(tif.tr_valid), 0);
        chk("rst_level", 64'(fifo_level), 0);
        chk("rst_class", 64'(tif.tr_class), 0);
        chk("rst_drop", 64'(drop_cnt), 0);
        chk("rst_cnt0", 64'(cnt_val), 0);
        chk("rst_level4", 64'(level4), 0);

        // NOP, ADD, LW, J
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; instr = p1[i]; pc = 32'h100 + 32'(4 * i);
            step();
        end
        en = 1'b0;
        chk("p1_cyc", 64'(cyc), 4);
        sel(5'd0);  chk("p1_cnt_nop", 64'(cnt_val), 1);
        sel(5'd1);  chk("p1_cnt_add", 64'(cnt_val), 1);
        sel(5'd11); chk("p1_cnt_lw", 64'(cnt_val), 1);
        sel(5'd15); chk("p1_cnt_j", 64'(cnt_val), 1);
        chk("p1_level", 64'(fifo_level), 3);
        for (int i = 0; i < 3; i++) begin
            chk("p1_head_class", 64'(tif.tr_class), 64'(c1[i]));
            chk("p1_head_pc", 64'(tif.tr_pc), 64'(32'h104 + 32'(4 * i)));
            chk("p1_head_ts", 64'(tif.tr_ts), 64'(i + 1));
            tif.tr_ready = 1'b1; step(); tif.tr_ready = 1'b0;
        end
        chk("p1_empty", 64'(tif.tr_valid), 0);

        // Overflow: DEPTH+3 ADD samples with no consumer
        clr = 1'b1; step(); clr = 1'b0;
        sel(5'd1); chk("clr_cnt_add", 64'(cnt_val), 0);
        t_first = cyc_m;
        for (int i = 0; i < 11; i++) begin
            en = 1'b1; instr = I_ADD; pc = 32'h200 + 32'(4 * i);
            step();
        end
        en = 1'b0;
        chk("ovf_level", 64'(fifo_level), 8);
        chk("ovf_drop", 64'(drop_cnt), 3);
        chk("ovf_cnt_add", 64'(cnt_val), 11);
        chk("ovf_head_pc", 64'(tif.tr_pc), 64'h200);
        chk("ovf_head_ts", 64'(tif.tr_ts), 64'(t_first));
        chk("ovf_head_class", 64'(tif.tr_class), 1);

        // Full FIFO: push SW and pop in the same cycle
        sw_ts = cyc_m;
        en = 1'b1; instr = I_SW; pc = 32'h300; tif.tr_ready = 1'b1;
        step();
        en = 1'b0; tif.tr_ready = 1'b0;
        chk("fpp_level", 64'(fifo_level), 8);
        chk("fpp_drop", 64'(drop_cnt), 3);
        chk("fpp_head_pc", 64'(tif.tr_pc), 64'h204);
        tif.tr_ready = 1'b1;
        repeat (7) step();
        tif.tr_ready = 1'b0;
        chk("tail_level", 64'(fifo_level), 1);
        chk("tail_class", 64'(tif.tr_class), 12);
        chk("tail_pc", 64'(tif.tr_pc), 64'h300);
        chk("tail_ts", 64'(tif.tr_ts), 64'(sw_ts));
        tif.tr_ready = 1'b1; step(); tif.tr_ready = 1'b0;
        chk("tail_empty", 64'(tif.tr_valid), 0);

        // Saturation on the 4-bit instance, then clear beats a same-cycle sample
        clr = 1'b1; step(); clr = 1'b0;
        tif.tr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            en = 1'b1; instr = I_BEQ; pc = 32'h500; step();
        end
        en = 1'b0;
        sel(5'd13);
        chk("sat_cnt16", 64'(cnt_val), 20);
        chk("sat_cnt4", 64'(cnt_val4), 15);
        clr = 1'b1; en = 1'b1; instr = I_BEQ; step();
        clr = 1'b0; en = 1'b0;
        chk("clr_en_cnt16", 64'(cnt_val), 0);
        chk("clr_en_cnt4", 64'(cnt_val4), 0);
        chk("clr_drop", 64'(drop_cnt), 0);

        // OTHER class and out-of-range readout
        en = 1'b1; instr = I_OTHER; pc = 32'h600; step(); en = 1'b0;
        sel(5'd20); chk("sel20_zero", 64'(cnt_val), 0);
        sel(5'd16); chk("other_cnt", 64'(cnt_val), 1);
        step(); step();
        tif.tr_ready = 1'b0;
        chk("drained", 64'(fifo_level), 0);

        // Mid-run reset with records queued
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; instr = I_ADD; pc = 32'h400 + 32'(4 * i); step();
        end
        en = 1'b0;
        chk("pre_rst_level", 64'(fifo_level), 5);
        sel(5'd1); chk("pre_rst_cnt", 64'(cnt_val), 5);
        rst = 1'b1; en = 1'b1; instr = I_ADD; step();
        rst = 1'b0; en = 1'b0;
        chk("mrst_valid", 64'(tif.tr_valid), 0);
        chk("mrst_level", 64'(fifo_level), 0);
        chk("mrst_cnt_add", 64'(cnt_val), 0);
        sel(5'd16); chk("mrst_cnt_other", 64'(cnt_val), 0);
        chk("mrst_pc", 64'(tif.tr_pc), 0);
        chk("mrst_cyc0", 64'(cyc), 0);
        step();
        chk("mrst_cyc1", 64'(cyc), 1);
        chk("mrst_cyc4", 64'(cyc4), 64'(cyc_m));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
